// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_ctrl_pkg : shared stall-bus codes, stage indices, FSM states |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package pipeline_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam int STG_PC    = 0;
    localparam int STG_IF_ID = 1;
    localparam int STG_ID_EX = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;
    localparam int STG_WB    = 5;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_EXCP_WAIT = 2'd1,
        ST_FLUSH     = 2'd2
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_stall_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_ctrl_stall_encoder : priority encoder, 4 requests -> stall   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module pipeline_ctrl_stall_encoder
    import pipeline_ctrl_pkg::*;
(
    input  logic               req_if,
    input  logic               req_id,
    input  logic               req_ex,
    input  logic               req_mem,
    output logic [STALL_W-1:0] code
);

    // Deeper stages win: a stall there must also freeze everything upstream.
    always_comb begin
        code = STALL_NONE;
        if (req_mem)     code = STALL_MEM;
        else if (req_ex) code = STALL_EX;
        else if (req_id) code = STALL_ID;
        else if (req_if) code = STALL_IF;
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_ctrl : stall/flush controller, exception redirect, watchdog  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 1023,
    parameter int unsigned CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               excp_valid,
    input  logic [31:0]        excp_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               stall_timeout,
    output logic [CNT_W-1:0]   stall_cycles
);

    localparam int             WD_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX    = WD_W'(TIMEOUT);
    localparam logic [3:0]     FLUSH_LOAD = 4'(FLUSH_CYCLES);

    ctrl_state_t        state;
    ctrl_state_t        state_next;
    logic [STALL_W-1:0] req_code;
    logic [31:0]        latched_pc;
    logic               latch_en;
    logic [3:0]         flush_cnt;
    logic [WD_W-1:0]    wd_cnt;
    logic [WD_W-1:0]    wd_next;

    pipeline_ctrl_stall_encoder u_stall_encoder (
        .req_if  (stallreq_if),
        .req_id  (stallreq_id),
        .req_ex  (stallreq_ex),
        .req_mem (stallreq_mem),
        .code    (req_code)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = STALL_NONE;
        flush      = 1'b0;
        new_pc     = 32'd0;
        latch_en   = 1'b0;
        if (rst) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    stall = req_code;
                    if (excp_valid) begin
                        latch_en = 1'b1;
                        if (stallreq_mem) begin
                            stall      = STALL_MEM;
                            state_next = ST_EXCP_WAIT;
                        end else begin
                            stall      = STALL_ALL;
                            state_next = ST_FLUSH;
                        end
                    end
                end
                ST_EXCP_WAIT: begin
                    // The data bus cannot be aborted, so the flush waits for it to drain.
                    stall = STALL_MEM | req_code;
                    if (!stallreq_mem) begin
                        stall      = STALL_ALL;
                        state_next = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    flush  = 1'b1;
                    new_pc = latched_pc;
                    if (flush_cnt <= 4'd1) state_next = ST_RUN;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)           latched_pc <= 32'd0;
        else if (latch_en) latched_pc <= excp_pc;
    end

    always_ff @(posedge clk) begin
        if (rst)
            flush_cnt <= 4'd0;
        else if (state != ST_FLUSH && state_next == ST_FLUSH)
            flush_cnt <= FLUSH_LOAD;
        else if (state == ST_FLUSH)
            flush_cnt <= flush_cnt - 4'd1;
    end

    always_comb begin
        wd_next = wd_cnt;
        if (state == ST_FLUSH || stall == STALL_NONE) wd_next = '0;
        else if (wd_cnt != WD_MAX)                    wd_next = wd_cnt + 1'b1;
    end

    // The flag is set on the edge where the counter reaches TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else begin
            wd_cnt <= wd_next;
            if (TIMEOUT != 0 && wd_next == WD_MAX) stall_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall[STG_PC] == STOP && stall_cycles != {CNT_W{1'b1}})
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipeline_ctrl : scoreboard bench for pipeline_ctrl                 |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_pipeline_ctrl;

    localparam int FLUSH_N = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        excp_valid = 1'b0;
    logic [31:0] excp_pc = 32'd0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        tmo;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic        exp_tmo = 1'b0;
    logic [31:0] exp_cyc = 32'd0;

    pipeline_ctrl #(.FLUSH_CYCLES(FLUSH_N), .TIMEOUT(8), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .excp_valid    (excp_valid),
        .excp_pc       (excp_pc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One stimulus cycle: {mem,ex,id,if} requests, exception inputs, expected outputs.
    task automatic step(input logic [3:0] req, input logic ev, input logic [31:0] epc,
                        input logic [5:0] es, input logic ef, input logic [31:0] ep);
        exp_t e;
        @(negedge clk);
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
        excp_valid = ev;
        excp_pc    = epc;
        e.stall  = es;
        e.flush  = ef;
        e.new_pc = ep;
        e.tmo    = exp_tmo;
        e.cyc    = exp_cyc;
        sb.push_back(e);
        if (es[0]) exp_cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
        excp_valid = 1'b0;
        excp_pc    = 32'd0;
        @(negedge clk);
        rst     = 1'b0;
        exp_cyc = 32'd0;
        exp_tmo = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("stall", {26'd0, stall}, {26'd0, e.stall});
            check_eq("flush", {31'd0, flush}, {31'd0, e.flush});
            check_eq("new_pc", new_pc, e.new_pc);
            check_eq("stall_timeout", {31'd0, stall_timeout}, {31'd0, e.tmo});
            check_eq("stall_cycles", stall_cycles, e.cyc);
        end
    end

    initial begin
        do_reset();
        // Idle after reset
        repeat (2) step(4'b0000, 1'b0, 32'd0, 6'b000000, 1'b0, 32'd0);
        // id + if together: id wins
        repeat (3) step(4'b0011, 1'b0, 32'd0, 6'b000111, 1'b0, 32'd0);
        step(4'b0000, 1'b0, 32'd0, 6'b000000, 1'b0, 32'd0);
        // Single if request, then ex beats id
        step(4'b0001, 1'b0, 32'd0, 6'b000011, 1'b0, 32'd0);
        step(4'b0110, 1'b0, 32'd0, 6'b001111, 1'b0, 32'd0);
        step(4'b0000, 1'b0, 32'd0, 6'b000000, 1'b0, 32'd0);
        // Exception with no mem request; requests and new exceptions ignored during flush
        step(4'b0000, 1'b1, 32'h380, 6'b111111, 1'b0, 32'd0);
        repeat (FLUSH_N) step(4'b0001, 1'b1, 32'h111, 6'b000000, 1'b1, 32'h380);
        step(4'b0000, 1'b0, 32'd0, 6'b000000, 1'b0, 32'd0);
        // Exception while mem busy; second exception ignored; flush follows release
        step(4'b1000, 1'b1, 32'h380, 6'b011111, 1'b0, 32'd0);
        step(4'b1000, 1'b1, 32'h200, 6'b011111, 1'b0, 32'd0);
        step(4'b1010, 1'b0, 32'd0,   6'b011111, 1'b0, 32'd0);
        step(4'b1000, 1'b0, 32'd0,   6'b011111, 1'b0, 32'd0);
        step(4'b0010, 1'b0, 32'd0,   6'b111111, 1'b0, 32'd0);
        repeat (FLUSH_N) step(4'b0000, 1'b0, 32'd0, 6'b000000, 1'b1, 32'h380);
        step(4'b0000, 1'b0, 32'd0, 6'b000000, 1'b0, 32'd0);
        // Watchdog: ex held 10 cycles, flag visible from the 9th cycle and sticky
        for (int i = 1; i <= 10; i++) begin
            exp_tmo = (i >= 9);
            step(4'b0100, 1'b0, 32'd0, 6'b001111, 1'b0, 32'd0);
        end
        repeat (2) step(4'b0000, 1'b0, 32'd0, 6'b000000, 1'b0, 32'd0);
        // Reset while in EXCP_WAIT aborts the exception
        step(4'b1000, 1'b1, 32'h444, 6'b011111, 1'b0, 32'd0);
        do_reset();
        repeat (4) step(4'b0000, 1'b0, 32'd0, 6'b000000, 1'b0, 32'd0);
        @(negedge clk);
        #5;
        if (sb.size() != 0) check_eq("scoreboard_drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
